// File: rtl/sound_addr_sequencer.sv
// Multi-channel sample-ROM address sequencer: each channel walks a base/length region in
// one-shot or loop mode, and a fixed-priority mux (channel 0 highest) drives the ROM address.
module sound_addr_sequencer #(
  parameter int unsigned N  = 16,
  parameter int unsigned CH = 4,
  parameter int unsigned SW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            Sound_clk,
  input  logic            Reset,
  input  logic [CH-1:0]   Play,
  input  logic [CH-1:0]   Stop,
  input  logic [CH-1:0]   Loop,
  input  logic [CH*N-1:0] Base,
  input  logic [CH*N-1:0] Len,
  output logic [N-1:0]    Addr,
  output logic [SW-1:0]   Ch_sel,
  output logic            Active,
  output logic [CH-1:0]   Playing,
  output logic [CH-1:0]   Done
);

  typedef enum logic {StIdle, StPlay} state_e;

  localparam logic [N-1:0] OffOne = N'(1);

  state_e       state_q [CH];
  state_e       state_d [CH];
  logic [N-1:0] off_q   [CH];
  logic [N-1:0] off_d   [CH];
  logic [N-1:0] base_q  [CH];
  logic [N-1:0] base_d  [CH];
  logic [N-1:0] len_q   [CH];
  logic [N-1:0] len_d   [CH];
  logic [CH-1:0] loop_q, loop_d;
  logic [CH-1:0] done_q, done_d;

  // Per-edge priority: Stop beats Play beats advance.
  always_comb begin
    done_d = '0;
    loop_d = loop_q;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      off_d[i]   = off_q[i];
      base_d[i]  = base_q[i];
      len_d[i]   = len_q[i];
      if (Stop[i]) begin
        state_d[i] = StIdle;
        off_d[i]   = '0;
      end else if (Play[i] && (Len[i*N +: N] != '0)) begin
        state_d[i] = StPlay;
        off_d[i]   = '0;
        base_d[i]  = Base[i*N +: N];
        len_d[i]   = Len[i*N +: N];
        loop_d[i]  = Loop[i];
      end else if (state_q[i] == StPlay) begin
        if (off_q[i] == len_q[i] - OffOne) begin
          off_d[i] = '0;
          if (!loop_q[i]) begin
            state_d[i] = StIdle;
            done_d[i]  = 1'b1;
          end
        end else begin
          off_d[i] = off_q[i] + OffOne;
        end
      end
    end
  end

  always_ff @(posedge Sound_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= StIdle;
        off_q[i]   <= '0;
        base_q[i]  <= '0;
        len_q[i]   <= '0;
      end
      loop_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        off_q[i]   <= off_d[i];
        base_q[i]  <= base_d[i];
        len_q[i]   <= len_d[i];
      end
      loop_q <= loop_d;
      done_q <= done_d;
    end
  end

  // Scan from the highest index down so the lowest playing channel wins.
  always_comb begin
    Addr    = '0;
    Ch_sel  = '0;
    Active  = 1'b0;
    Playing = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (state_q[i] == StPlay) begin
        Playing[i] = 1'b1;
        Active     = 1'b1;
        Ch_sel     = SW'(i);
        Addr       = base_q[i] + off_q[i];
      end
    end
  end

  assign Done = done_q;

endmodule

// File: tb/tb_sound_addr_sequencer.sv
// Bench for sound_addr_sequencer (CH=2, N=8): directed scenarios plus randomized traffic
// compared against a sample-count model of each channel.
module tb_sound_addr_sequencer;

  logic        Sound_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Play = '0, Stop = '0, Loop = '0;
  logic [15:0] Base = '0, Len = '0;
  logic [7:0]  Addr;
  logic [0:0]  Ch_sel;
  logic        Active;
  logic [1:0]  Playing, Done;

  int chk_cnt = 0;
  int pass_cnt = 0;

  sound_addr_sequencer #(.N(8), .CH(2)) dut (
    .Sound_clk(Sound_clk),
    .Reset    (Reset),
    .Play     (Play),
    .Stop     (Stop),
    .Loop     (Loop),
    .Base     (Base),
    .Len      (Len),
    .Addr     (Addr),
    .Ch_sel   (Ch_sel),
    .Active   (Active),
    .Playing  (Playing),
    .Done     (Done)
  );

  always #5 Sound_clk = ~Sound_clk;

  logic [13:0] obs;
  assign obs = {Addr, Ch_sel, Active, Playing, Done};

  function automatic logic [13:0] ev(input logic [7:0] a, input logic s, input logic act,
                                     input logic [1:0] p, input logic [1:0] d);
    return {a, s, act, p, d};
  endfunction

  // Reference model: a channel is either silent or somewhere inside its sound.
  int m_on[2], m_off[2], m_base[2], m_len[2], m_loop[2], m_done[2];

  task automatic model_edge(input logic [1:0] pl, input logic [1:0] st, input logic [1:0] lp,
                            input logic [15:0] bs, input logic [15:0] ln);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (st[i]) begin
        m_on[i] = 0;
        m_off[i] = 0;
      end else if (pl[i] && ln[i*8 +: 8] != 8'd0) begin
        m_on[i] = 1;
        m_off[i] = 0;
        m_base[i] = int'(bs[i*8 +: 8]);
        m_len[i] = int'(ln[i*8 +: 8]);
        m_loop[i] = int'(lp[i]);
      end else if (m_on[i] != 0) begin
        m_off[i] = m_off[i] + 1;
        if (m_off[i] == m_len[i]) begin
          m_off[i] = 0;
          if (m_loop[i] == 0) begin
            m_on[i] = 0;
            m_done[i] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [13:0] model_obs();
    logic [7:0] a = 8'd0;
    logic s = 1'b0;
    logic act = 1'b0;
    for (int i = 1; i >= 0; i--) begin
      if (m_on[i] != 0) begin
        act = 1'b1;
        s = 1'(i);
        a = 8'((m_base[i] + m_off[i]) % 256);
      end
    end
    return {a, s, act, (m_on[1] != 0), (m_on[0] != 0), (m_done[1] != 0), (m_done[0] != 0)};
  endfunction

  task automatic edge_wait();
    @(posedge Sound_clk);
    #1;
  endtask

  task automatic quiet_reset();
    Play = '0; Stop = '0; Loop = '0; Base = '0; Len = '0;
    #2 Reset = 1'b1;
    edge_wait();
    #3 Reset = 1'b0;
    edge_wait();
  endtask

  task automatic test_reset();
    logic [13:0] e;
    Reset = 1'b1;
    Play = 2'b11; Base = 16'h2010; Len = 16'h0505;
    #2;
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL reset_initial: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    chk_cnt++;
    if (obs !== e) $display("FAIL reset_held_play: got %h want %h", obs, e);
    else pass_cnt++;
    Play = '0; Base = '0; Len = '0;
    #3 Reset = 1'b0;
    edge_wait();
  endtask

  task automatic test_oneshot();
    logic [13:0] e;
    Base = 16'h0010; Len = 16'h0004; Loop = 2'b00; Play = 2'b01;
    for (int k = 0; k < 4; k++) begin
      edge_wait();
      Play = '0;
      e = ev(8'h10 + 8'(k), 1'b0, 1'b1, 2'b01, 2'b00);
      chk_cnt++;
      if (obs !== e) $display("FAIL oneshot_k%0d: got %h want %h", k, obs, e);
      else pass_cnt++;
    end
    edge_wait();
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b01);
    chk_cnt++;
    if (obs !== e) $display("FAIL oneshot_done: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL oneshot_done_clear: got %h want %h", obs, e);
    else pass_cnt++;
  endtask

  task automatic test_loop();
    logic [13:0] e;
    logic [7:0] seq [3] = '{8'hFE, 8'hFF, 8'h00};
    Base = 16'h00FE; Len = 16'h0003; Loop = 2'b01; Play = 2'b01;
    for (int k = 0; k < 7; k++) begin
      edge_wait();
      Play = '0;
      e = ev(seq[k % 3], 1'b0, 1'b1, 2'b01, 2'b00);
      chk_cnt++;
      if (obs !== e) $display("FAIL loop_k%0d: got %h want %h", k, obs, e);
      else pass_cnt++;
    end
    Stop = 2'b01;
    edge_wait();
    Stop = '0;
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL loop_stop: got %h want %h", obs, e);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [13:0] e;
    Base = 16'h4000; Len = 16'h1400; Loop = 2'b00; Play = 2'b10;
    for (int k = 0; k < 6; k++) begin
      edge_wait();
      Play = '0;
    end
    e = ev(8'h45, 1'b1, 1'b1, 2'b10, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL prio_ch1_off5: got %h want %h", obs, e);
    else pass_cnt++;
    Base = 16'h0010; Len = 16'h0002; Play = 2'b01;
    edge_wait();
    Play = '0;
    e = ev(8'h10, 1'b0, 1'b1, 2'b11, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL prio_ch0_a: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    e = ev(8'h11, 1'b0, 1'b1, 2'b11, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL prio_ch0_b: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    e = ev(8'h48, 1'b1, 1'b1, 2'b10, 2'b01);
    chk_cnt++;
    if (obs !== e) $display("FAIL prio_unmask: got %h want %h", obs, e);
    else pass_cnt++;
    Stop = 2'b10;
    edge_wait();
    Stop = '0;
  endtask

  task automatic test_stop_play();
    logic [13:0] e;
    Base = 16'h0020; Len = 16'h000A; Loop = 2'b00; Play = 2'b01;
    for (int k = 0; k < 3; k++) begin
      edge_wait();
      Play = '0;
    end
    e = ev(8'h22, 1'b0, 1'b1, 2'b01, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL stopplay_pre: got %h want %h", obs, e);
    else pass_cnt++;
    Stop = 2'b01; Play = 2'b01;
    edge_wait();
    Stop = '0; Play = '0;
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL stopplay_same_edge: got %h want %h", obs, e);
    else pass_cnt++;
  endtask

  task automatic test_len_zero();
    logic [13:0] e;
    Base = 16'h0033; Len = 16'h0000; Play = 2'b01;
    edge_wait();
    Play = '0;
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL lenzero_idle: got %h want %h", obs, e);
    else pass_cnt++;
    Len = 16'h0005; Play = 2'b01;
    edge_wait();
    Base = 16'h0099; Len = 16'h0000; Play = 2'b01;
    edge_wait();
    Play = '0;
    e = ev(8'h34, 1'b0, 1'b1, 2'b01, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL lenzero_playing: got %h want %h", obs, e);
    else pass_cnt++;
    Stop = 2'b01;
    edge_wait();
    Stop = '0;
  endtask

  task automatic test_retrigger();
    logic [13:0] e;
    Base = 16'h0030; Len = 16'h000A; Loop = 2'b00; Play = 2'b01;
    for (int k = 0; k < 4; k++) begin
      edge_wait();
      Play = '0;
    end
    Base = 16'h0080; Len = 16'h0002; Play = 2'b01;
    edge_wait();
    Play = '0;
    e = ev(8'h80, 1'b0, 1'b1, 2'b01, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL retrig_a: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    e = ev(8'h81, 1'b0, 1'b1, 2'b01, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL retrig_b: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b01);
    chk_cnt++;
    if (obs !== e) $display("FAIL retrig_done: got %h want %h", obs, e);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [13:0] e;
    Base = 16'h0050; Len = 16'h000A; Loop = 2'b01; Play = 2'b01;
    for (int k = 0; k < 3; k++) begin
      edge_wait();
      Play = '0;
    end
    #2 Reset = 1'b1;
    #1;
    e = ev(8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL async_reset: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    #3 Reset = 1'b0;
    Base = 16'h0060; Len = 16'h0003; Loop = 2'b00; Play = 2'b01;
    edge_wait();
    Play = '0;
    e = ev(8'h60, 1'b0, 1'b1, 2'b01, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL post_reset_a: got %h want %h", obs, e);
    else pass_cnt++;
    edge_wait();
    e = ev(8'h61, 1'b0, 1'b1, 2'b01, 2'b00);
    chk_cnt++;
    if (obs !== e) $display("FAIL post_reset_b: got %h want %h", obs, e);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [13:0] e;
    quiet_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_off[i] = 0; m_base[i] = 0; m_len[i] = 0; m_loop[i] = 0; m_done[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        Play[i] = ($urandom_range(0, 5) == 0);
        Stop[i] = ($urandom_range(0, 15) == 0);
        Loop[i] = 1'($urandom);
        Base[i*8 +: 8] = 8'($urandom);
        Len[i*8 +: 8] = 8'($urandom_range(0, 6));
      end
      model_edge(Play, Stop, Loop, Base, Len);
      edge_wait();
      e = model_obs();
      chk_cnt++;
      if (obs !== e) $display("FAIL random_c%0d: got %h want %h", c, obs, e);
      else pass_cnt++;
    end
    Play = '0; Stop = '0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_priority();
    test_stop_play();
    test_len_zero();
    test_retrigger();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
